text_scan_8x16: RTL and testbench

Video-side reader for the 80x30 character/attribute RAM and the 8x8 font ROM. It takes pixel coordinates and sync from the video timing generator and generates the scan address. It fetches character and attribute, drives the font ROM with the vertically doubled row (8x8 glyph shown in an 8x16 cell), then applies the attribute, blink and cursor. Output is 24-bit RGB with DE/HSYNC/VSYNC aligned, feeding the HDMI/DVI encoder.

---
 rtl/text_scan_8x16_pkg.sv | 54 +++++
 rtl/text_scan_8x16_if.sv | 52 +++++
 rtl/text_scan_8x16_blink_ctr.sv | 52 +++++
 rtl/text_scan_8x16.sv | 166 ++++++++++++++++
 tb/tb_text_scan_8x16.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/text_scan_8x16_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_pkg                                                     |
// | Description : Shared constants, attribute layout and CGA palette for the   |
// |               80x30 text-mode scanout path.                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package text_pkg;

    localparam int TEXT_COLS    = 80;
    localparam int TEXT_ROWS    = 30;
    localparam int CELL_W       = 8;
    localparam int CELL_H       = 16;
    localparam int SCAN_LATENCY = 4;

    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } attr_t;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } blink_phase_t;

    function automatic logic [23:0] palette_rgb(input logic [3:0] idx);
        logic [23:0] rgb;
        rgb = 24'h000000;
        case (idx)
            4'd0:  rgb = 24'h000000;
            4'd1:  rgb = 24'h0000AA;
            4'd2:  rgb = 24'h00AA00;
            4'd3:  rgb = 24'h00AAAA;
            4'd4:  rgb = 24'hAA0000;
            4'd5:  rgb = 24'hAA00AA;
            4'd6:  rgb = 24'hAA5500;
            4'd7:  rgb = 24'hAAAAAA;
            4'd8:  rgb = 24'h555555;
            4'd9:  rgb = 24'h5555FF;
            4'd10: rgb = 24'h55FF55;
            4'd11: rgb = 24'h55FFFF;
            4'd12: rgb = 24'hFF5555;
            4'd13: rgb = 24'hFF55FF;
            4'd14: rgb = 24'hFFFF55;
            4'd15: rgb = 24'hFFFFFF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_scan_8x16_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_scan_8x16_if                                            |
// | Description : Timing-in, char/font memory and video-out signal bundle.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface text_scan_8x16_if;

    logic        de_in;
    logic        hs_in;
    logic        vs_in;
    logic [9:0]  x_in;
    logic [9:0]  y_in;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        v_en;
    logic [11:0] v_addr;
    logic [7:0]  v_char;
    logic [7:0]  v_attr;
    logic [7:0]  font_char;
    logic [2:0]  font_row;
    logic [7:0]  font_pixels;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;

    // The scanner is the master: it issues RAM/ROM addresses and drives video out.
    modport master (
        input  de_in, hs_in, vs_in, x_in, y_in,
        input  cursor_en, cursor_col, cursor_row,
        output v_en, v_addr,
        input  v_char, v_attr,
        output font_char, font_row,
        input  font_pixels,
        output rgb_out, de_out, hs_out, vs_out
    );

    modport slave (
        output de_in, hs_in, vs_in, x_in, y_in,
        output cursor_en, cursor_col, cursor_row,
        input  v_en, v_addr,
        output v_char, v_attr,
        input  font_char, font_row,
        output font_pixels,
        input  rgb_out, de_out, hs_out, vs_out
    );

endinterface
`default_nettype wire

// File: rtl/text_scan_8x16_blink_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_blink_ctr                                               |
// | Description : Counts vsync rising edges and toggles the blink phase every  |
// |               BLINK_FRAMES frames.                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module text_blink_ctr
    import text_pkg::*;
#(
    parameter int BLINK_FRAMES = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   i_vs,
    output blink_phase_t o_phase
);

    localparam int c_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLINK_FRAMES - 1);

    logic               r_vs_d;
    logic [c_CNT_W-1:0] r_cnt;
    blink_phase_t       r_phase;
    logic               w_vs_rise;

    // A held-high vsync yields exactly one rising edge.
    assign w_vs_rise = i_vs & ~r_vs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d  <= 1'b0;
            r_cnt   <= '0;
            r_phase <= PHASE_VISIBLE;
        end else begin
            r_vs_d <= i_vs;
            if (w_vs_rise) begin
                if (r_cnt == c_LAST) begin
                    r_cnt   <= '0;
                    r_phase <= (r_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/text_scan_8x16.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_scan_8x16                                               |
// | Description : 4-stage text-mode scanout: char/attr fetch, 8x8 font lookup  |
// |               with doubled rows, attribute/blink/cursor, RGB out.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module text_scan_8x16
    import text_pkg::*;
#(
    parameter int COLS         = TEXT_COLS,
    parameter int ROWS         = TEXT_ROWS,
    parameter int BLINK_FRAMES = 32,
    parameter int CURSOR_START = 14
) (
    input  wire logic         clk,
    input  wire logic         rst,
    text_scan_8x16_if.master  bus
);

    localparam int c_XB_W = $clog2(CELL_W);
    localparam int c_SL_W = $clog2(CELL_H);
    localparam logic [6:0]        c_COLS      = 7'(COLS);
    localparam logic [4:0]        c_ROWS      = 5'(ROWS);
    localparam logic [c_SL_W-1:0] c_CUR_START = c_SL_W'(CURSOR_START);

    // ---------------- S1: address generation ----------------
    logic [6:0]        w_col;
    logic [4:0]        w_row;
    logic [c_SL_W-1:0] w_scan;
    logic [11:0]       w_row_ext;
    logic [11:0]       w_addr;
    logic              w_in_range;
    logic              w_cur_hit;
    logic              w_unused_y9;

    assign w_col       = bus.x_in[9:3];
    assign w_row       = bus.y_in[8:4];
    assign w_scan      = bus.y_in[3:0];
    assign w_unused_y9 = bus.y_in[9];
    assign w_row_ext   = {7'd0, w_row};
    // row*80 as two shifts keeps this a pair of adders.
    assign w_addr      = (w_row_ext << 6) + (w_row_ext << 4) + {5'd0, w_col};
    assign w_in_range  = bus.de_in && (w_col < c_COLS) && (w_row < c_ROWS);
    assign w_cur_hit   = bus.cursor_en && (w_col == bus.cursor_col) &&
                         (w_row == bus.cursor_row) && (w_scan >= c_CUR_START);

    logic              r1_v_en;
    logic [11:0]       r1_v_addr;
    logic [c_XB_W-1:0] r1_xbit;
    logic [c_SL_W-1:0] r1_scan;
    logic              r1_cur;

    logic [2:0]        r2_font_row;
    logic [c_XB_W-1:0] r2_xbit;
    logic              r2_valid;
    logic              r2_cur;

    attr_t             r3_attr;
    logic [c_XB_W-1:0] r3_xbit;
    logic              r3_valid;
    logic              r3_cur;

    logic [23:0]       r4_rgb;

    // {de, hs, vs} delay line; tap SCAN_LATENCY-2 aligns with S3 data.
    logic [2:0]        r_sync [SCAN_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_v_en     <= 1'b0;
            r1_v_addr   <= '0;
            r1_xbit     <= '0;
            r1_scan     <= '0;
            r1_cur      <= 1'b0;
            r2_font_row <= '0;
            r2_xbit     <= '0;
            r2_valid    <= 1'b0;
            r2_cur      <= 1'b0;
            r3_attr     <= '0;
            r3_xbit     <= '0;
            r3_valid    <= 1'b0;
            r3_cur      <= 1'b0;
        end else begin
            r1_v_en <= w_in_range;
            if (w_in_range) begin
                r1_v_addr <= w_addr;
            end
            r1_xbit     <= bus.x_in[2:0];
            r1_scan     <= w_scan;
            r1_cur      <= w_cur_hit;

            r2_font_row <= r1_scan[3:1];
            r2_xbit     <= r1_xbit;
            r2_valid    <= r1_v_en;
            r2_cur      <= r1_cur;

            r3_attr     <= attr_t'(bus.v_attr);
            r3_xbit     <= r2_xbit;
            r3_valid    <= r2_valid;
            r3_cur      <= r2_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SCAN_LATENCY; i++) begin
                r_sync[i] <= 3'b000;
            end
        end else begin
            r_sync[0] <= {bus.de_in, bus.hs_in, bus.vs_in};
            for (int i = 1; i < SCAN_LATENCY; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // ---------------- blink phase ----------------
    blink_phase_t w_phase;

    text_blink_ctr #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_vs    (bus.vs_in),
        .o_phase (w_phase)
    );

    // ---------------- S3/S4: pixel select and colour ----------------
    logic       w_hidden;
    logic       w_pix_raw;
    logic       w_pix_blink;
    logic       w_pix;
    logic [3:0] w_idx;
    logic       w_s3_de;

    assign w_hidden    = (w_phase == PHASE_HIDDEN);
    assign w_pix_raw   = bus.font_pixels[3'd7 - r3_xbit];
    assign w_pix_blink = w_pix_raw & ~(r3_attr.blink & w_hidden);
    assign w_pix       = w_pix_blink ^ (r3_cur & ~w_hidden);
    assign w_idx       = w_pix ? r3_attr.fg : {1'b0, r3_attr.bg};
    assign w_s3_de     = r_sync[SCAN_LATENCY-2][2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r4_rgb <= 24'h000000;
        end else if (w_s3_de && r3_valid) begin
            r4_rgb <= palette_rgb(w_idx);
        end else begin
            r4_rgb <= 24'h000000;
        end
    end

    assign bus.v_en      = r1_v_en;
    assign bus.v_addr    = r1_v_addr;
    assign bus.font_char = bus.v_char;
    assign bus.font_row  = r2_font_row;
    assign bus.rgb_out   = r4_rgb;
    assign bus.de_out    = r_sync[SCAN_LATENCY-1][2];
    assign bus.hs_out    = r_sync[SCAN_LATENCY-1][1];
    assign bus.vs_out    = r_sync[SCAN_LATENCY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_text_scan_8x16.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_text_scan_8x16                                            |
// | Description : Scoreboard bench with char RAM / font ROM models.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_text_scan_8x16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_scan_8x16_if bus ();

    text_scan_8x16 #(
        .COLS         (80),
        .ROWS         (30),
        .BLINK_FRAMES (32),
        .CURSOR_START (14)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Memory models: 1-clk registered reads.
    logic [7:0]  ram_c [2400];
    logic [7:0]  ram_a [2400];
    logic [7:0]  font_mem [256][8];
    logic [23:0] pal [16];

    always @(posedge clk) begin
        if (bus.v_en) begin
            bus.v_char <= ram_c[bus.v_addr];
            bus.v_attr <= ram_a[bus.v_addr];
        end
    end

    always @(posedge clk) bus.font_pixels <= font_mem[bus.font_char][bus.font_row];

    // Blink model state, advanced as vsync is driven.
    int frames = 0;
    bit hidden = 1'b0;
    bit prev_vs = 1'b0;

    typedef struct {int due; logic [23:0] rgb; logic de; logic hs; logic vs;} vid_t;
    typedef struct {int due; logic en; logic [11:0] addr;} ram_t;
    vid_t vq[$];
    ram_t rq[$];
    ram_t fq[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] exp_rgb(input logic de, input logic [9:0] x, input logic [9:0] y);
        int col, row, idx;
        logic [7:0] ch, at, fp;
        logic pix;
        col = int'(x) / 8;
        row = int'(y) / 16;
        if (!de || col >= 80 || row >= 30) return 24'h000000;
        idx = row * 80 + col;
        ch  = ram_c[idx];
        at  = ram_a[idx];
        fp  = font_mem[ch][(int'(y) % 16) / 2];
        pix = fp[7 - (int'(x) % 8)];
        if (at[7] && hidden) pix = 1'b0;
        if (bus.cursor_en && col == int'(bus.cursor_col) && row == int'(bus.cursor_row) &&
            (int'(y) % 16) >= 14 && !hidden) pix = ~pix;
        return pix ? pal[at[3:0]] : pal[{1'b0, at[6:4]}];
    endfunction

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [9:0] x, input logic [9:0] y);
        vid_t v;
        ram_t r;
        ram_t f;
        int col, row;
        @(negedge clk);
        bus.de_in = de;
        bus.hs_in = hs;
        bus.vs_in = vs;
        bus.x_in  = x;
        bus.y_in  = y;
        if (vs && !prev_vs) begin
            if (frames == 31) begin
                frames = 0;
                hidden = !hidden;
            end else begin
                frames++;
            end
        end
        prev_vs = vs;
        col    = int'(x) / 8;
        row    = int'(y) / 16;
        r.due  = cyc + 1;
        r.en   = de && col < 80 && row < 30;
        r.addr = 12'(row * 80 + col);
        rq.push_back(r);
        f.due  = cyc + 2;
        f.en   = r.en;
        f.addr = 12'((int'(y) % 16) / 2);
        fq.push_back(f);
        v.due  = cyc + 4;
        v.rgb  = exp_rgb(de, x, y);
        v.de   = de;
        v.hs   = hs;
        v.vs   = vs;
        vq.push_back(v);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
            drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        end
    endtask

    task automatic draw_cell(input int x0, input int y);
        for (int x = x0; x < x0 + 8; x++) drive(1'b1, 1'b1, 1'b0, 10'(x), 10'(y));
    endtask

    // Scoreboard consumer.
    always @(posedge clk) begin
        vid_t v;
        ram_t r;
        #1;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            check_val("v_en", {31'd0, bus.v_en}, {31'd0, r.en});
            if (r.en) check_val("v_addr", {20'd0, bus.v_addr}, {20'd0, r.addr});
        end
        while (fq.size() > 0 && fq[0].due <= cyc) begin
            r = fq.pop_front();
            if (r.en) check_val("font_row", {29'd0, bus.font_row}, {20'd0, r.addr});
        end
        while (vq.size() > 0 && vq[0].due <= cyc) begin
            v = vq.pop_front();
            check_val("rgb_out", {8'd0, bus.rgb_out}, {8'd0, v.rgb});
            check_val("sync_out", {29'd0, bus.de_out, bus.hs_out, bus.vs_out},
                      {29'd0, v.de, v.hs, v.vs});
        end
    end

    initial begin
        pal = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
        for (int i = 0; i < 2400; i++) begin
            ram_c[i] = 8'h00;
            ram_a[i] = 8'h07;
        end
        for (int c = 0; c < 256; c++)
            for (int r = 0; r < 8; r++)
                font_mem[c][r] = (c == 255) ? 8'hFF : 8'h00;
        font_mem[8'h41][0] = 8'h18;
        ram_c[0] = 8'h41; ram_a[0] = 8'h07;
        ram_c[1] = 8'hFF; ram_a[1] = 8'h1E;
        ram_c[2] = 8'h00; ram_a[2] = 8'h1E;
        ram_c[3] = 8'hFF; ram_a[3] = 8'h87;

        bus.de_in = 1'b0; bus.hs_in = 1'b0; bus.vs_in = 1'b0;
        bus.x_in = '0; bus.y_in = '0;
        bus.cursor_en = 1'b0; bus.cursor_col = '0; bus.cursor_row = '0;

        // Reset held with active timing present.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.de_in = 1'b1;
            bus.hs_in = i[0];
            bus.x_in  = 10'(i * 8);
            @(posedge clk);
            #1;
            check_val("rst_rgb", {8'd0, bus.rgb_out}, 32'd0);
            check_val("rst_de", {31'd0, bus.de_out}, 32'd0);
            check_val("rst_ven", {31'd0, bus.v_en}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.de_in = 1'b0; bus.hs_in = 1'b0; bus.x_in = '0;
        @(posedge clk);
        #1;
        check_val("rel_all", {bus.rgb_out, bus.de_out, bus.hs_out, bus.vs_out, bus.v_en, bus.font_row},
                  32'd0);
        check_val("rel_addr", {20'd0, bus.v_addr}, 32'd0);

        // Address map and range boundaries.
        drive(1'b1, 1'b0, 1'b0, 10'd0,   10'd0);
        drive(1'b1, 1'b0, 1'b0, 10'd639, 10'd479);
        drive(1'b1, 1'b0, 1'b0, 10'd8,   10'd16);
        drive(1'b0, 1'b0, 1'b0, 10'd16,  10'd16);
        drive(1'b1, 1'b0, 1'b0, 10'd640, 10'd0);
        drive(1'b1, 1'b0, 1'b0, 10'd0,   10'd480);
        idle(6);

        // Glyph, attribute colours, blink cell visible.
        draw_cell(0, 0);
        draw_cell(0, 1);
        draw_cell(8, 0);
        draw_cell(16, 0);
        draw_cell(24, 0);

        // Cursor at (5,2): lines 45..47, plus neighbour column.
        bus.cursor_en = 1'b1; bus.cursor_col = 7'd5; bus.cursor_row = 5'd2;
        draw_cell(40, 45);
        draw_cell(40, 46);
        draw_cell(44, 47);
        idle(6);

        pulse(31);
        idle(4);
        draw_cell(24, 0);
        idle(6);
        pulse(1);
        idle(4);
        draw_cell(24, 0);
        draw_cell(40, 46);
        draw_cell(0, 0);
        idle(6);

        pulse(31);
        repeat (100) drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        idle(6);
        draw_cell(24, 0);
        draw_cell(40, 47);
        idle(6);
        pulse(31);
        idle(4);
        draw_cell(24, 0);
        idle(8);

        for (int i = 0; i < 50 && (vq.size() + rq.size() + fq.size()) > 0; i++) @(posedge clk);
        #2;
        check_val("drain", 32'(vq.size() + rq.size() + fq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
